// File: rtl/meas_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// meas_sequencer_pkg
// Shared definitions for the measurement sequencer:
//   - state_t      : sequencer FSM state encoding
//   - CS_*         : chip-select codes driven on cs_sel
//   - MUX_*        : analog multiplexer channel codes driven on mux_chn
//   - DIAP_*       : one-hot range codes driven on diap
//   - key_for_mode : keys field of the SPI register word for a given mode
// ---------------------------------------------------------------------------
package meas_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RANGE_SET,
      S_RANGE_WAIT,
      S_SET_REG,
      S_WAIT_REG,
      S_GEN_ON,
      S_SET_MUX,
      S_SETTLE,
      S_MEASURE,
      S_WAIT_ADC,
      S_PUSH1,
      S_PUSH2,
      S_GEN_OFF,
      S_NEXT_MODE,
      S_DONE
   } state_t;

   localparam logic [1:0] CS_NONE = 2'b11;
   localparam logic [1:0] CS_REG  = 2'b10;
   localparam logic [1:0] CS_DAC  = 2'b01;

   localparam logic [2:0] MUX_NONE      = 3'b000;
   localparam logic [2:0] MUX_CURRENT   = 3'b010;
   localparam logic [2:0] MUX_POTENTIAL = 3'b001;

   localparam logic [2:0] DIAP_5V  = 3'b001;
   localparam logic [2:0] DIAP_10V = 3'b010;
   localparam logic [2:0] DIAP_20V = 3'b100;

   localparam int KEYS_W = 5;

   // The relay key code of mode m is simply m.
   function automatic logic [KEYS_W-1:0] key_for_mode(input logic [KEYS_W-1:0] mode);
      return mode;
   endfunction

endpackage

// File: rtl/meas_sequencer_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Down-counter counting generator periods after a mux change.
//   clk, rst : clock, synchronous active-high reset
//   load     : load counter with value (wins over tick)
//   value    : number of periods to wait
//   tick     : one-cycle generator-period pulse, decrements while non-zero
//   zero     : counter is zero
// ---------------------------------------------------------------------------
module settle_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             tick,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (tick && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/meas_sequencer.sv
// ---------------------------------------------------------------------------
// meas_sequencer
// Runs a measurement sequence: one ranging conversion selects the voltage
// range, then every enabled mode programs the SPI register, switches the
// generator on, measures current (and potential for modes >= 2) after a
// settle period, and pushes both ADC results of every pass into the FIFO.
//   clk, rst                  : clock, synchronous active-high reset
//   enable, abort             : start level / terminate pulse
//   mode_mask, settle_periods : sequence configuration, captured at start
//   gen_new_period            : generator period pulse
//   gen_enable                : generator run enable
//   reg_data/reg_start/reg_done : SPI register word, start, completion
//   cs_sel, mux_chn           : chip-select and analog mux codes
//   adc_start/adc_range/adc_done/adc_data_1/adc_data_2 : ADC handshake
//   fifo_data/fifo_wr/fifo_full : FIFO write port
//   busy, done, diap          : status, end pulse, selected range
// ---------------------------------------------------------------------------
module meas_sequencer
   import meas_sequencer_pkg::*;
#(
   parameter int                  NUM_MODES = 5,
   parameter int                  DATA_W    = 24,
   parameter int                  SETTLE_W  = 4,
   parameter logic [DATA_W-1:0]   TH_LO     = 24'h200000,
   parameter logic [DATA_W-1:0]   TH_HI     = 24'h600000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 abort,
   input  logic [NUM_MODES-1:0] mode_mask,
   input  logic [SETTLE_W-1:0]  settle_periods,
   input  logic                 gen_new_period,
   output logic                 gen_enable,
   output logic [7:0]           reg_data,
   output logic                 reg_start,
   input  logic                 reg_done,
   output logic [1:0]           cs_sel,
   output logic [2:0]           mux_chn,
   output logic                 adc_start,
   output logic                 adc_range,
   input  logic                 adc_done,
   input  logic [DATA_W-1:0]    adc_data_1,
   input  logic [DATA_W-1:0]    adc_data_2,
   output logic [DATA_W-1:0]    fifo_data,
   output logic                 fifo_wr,
   input  logic                 fifo_full,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           diap
);

   state_t                state_reg, state_next;
   logic                  gen_enable_reg, gen_enable_next;
   logic [1:0]            cs_sel_reg, cs_sel_next;
   logic [2:0]            mux_chn_reg, mux_chn_next;
   logic [2:0]            diap_reg, diap_next;
   logic [7:0]            reg_data_reg, reg_data_next;
   logic [DATA_W-1:0]     fifo_data_reg, fifo_data_next;
   logic [DATA_W-1:0]     data2_reg, data2_next;
   logic [NUM_MODES-1:0]  pend_reg, pend_next;     // enabled modes not yet run
   logic [KEYS_W-1:0]     mode_reg, mode_next;     // current mode number (1-based)
   logic                  pass_reg, pass_next;     // 0 = current, 1 = potential
   logic [SETTLE_W-1:0]   settle_reg, settle_next;

   logic [NUM_MODES-1:0]  cur_onehot;
   logic [KEYS_W-1:0]     first_mode;
   logic                  any_pend;
   logic [2:0]            range_diap;
   logic                  settle_zero;

   function automatic logic [2:0] classify(input logic [DATA_W-1:0] r);
      if (r < TH_LO) begin
         return DIAP_5V;
      end else if (r < TH_HI) begin
         return DIAP_10V;
      end
      return DIAP_20V;
   endfunction

   // One-hot of the running mode, used to retire it from the pending set.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_MODES; gi++) begin : g_cur
         assign cur_onehot[gi] = (mode_reg == KEYS_W'(gi + 1));
      end
   endgenerate

   // Lowest pending mode: skipped modes cost no cycles.
   always_comb begin
      first_mode = '0;
      for (int i = NUM_MODES - 1; i >= 0; i--) begin
         if (pend_reg[i]) begin
            first_mode = KEYS_W'(i + 1);
         end
      end
   end

   assign any_pend   = |pend_reg;
   assign range_diap = classify(adc_data_1);

   settle_timer #(
      .WIDTH (SETTLE_W)
   ) u_settle_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (state_reg == S_SET_MUX),
      .value (settle_reg),
      .tick  (gen_new_period),
      .zero  (settle_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         gen_enable_reg <= 1'b0;
         cs_sel_reg     <= CS_NONE;
         mux_chn_reg    <= MUX_NONE;
         diap_reg       <= DIAP_20V;
         reg_data_reg   <= '0;
         fifo_data_reg  <= '0;
         data2_reg      <= '0;
         pend_reg       <= '0;
         mode_reg       <= '0;
         pass_reg       <= 1'b0;
         settle_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         gen_enable_reg <= gen_enable_next;
         cs_sel_reg     <= cs_sel_next;
         mux_chn_reg    <= mux_chn_next;
         diap_reg       <= diap_next;
         reg_data_reg   <= reg_data_next;
         fifo_data_reg  <= fifo_data_next;
         data2_reg      <= data2_next;
         pend_reg       <= pend_next;
         mode_reg       <= mode_next;
         pass_reg       <= pass_next;
         settle_reg     <= settle_next;
      end
   end

   // Registered outputs are loaded on the transition into the state that
   // owns them, so they are valid for the whole of that state.
   always_comb begin
      state_next      = state_reg;
      gen_enable_next = gen_enable_reg;
      cs_sel_next     = cs_sel_reg;
      mux_chn_next    = mux_chn_reg;
      diap_next       = diap_reg;
      reg_data_next   = reg_data_reg;
      fifo_data_next  = fifo_data_reg;
      data2_next      = data2_reg;
      pend_next       = pend_reg;
      mode_next       = mode_reg;
      pass_next       = pass_reg;
      settle_next     = settle_reg;

      case (state_reg)
         S_IDLE: begin
            if (enable && gen_new_period) begin
               state_next    = S_RANGE_SET;
               pend_next     = mode_mask;
               settle_next   = settle_periods;
               diap_next     = DIAP_20V;
               mux_chn_next  = MUX_CURRENT;
               reg_data_next = {DIAP_20V, key_for_mode(KEYS_W'(1))};
            end
         end
         S_RANGE_SET: state_next = S_RANGE_WAIT;
         S_RANGE_WAIT: begin
            if (adc_done) begin
               diap_next    = range_diap;
               mux_chn_next = MUX_NONE;
               if (any_pend) begin
                  state_next    = S_SET_REG;
                  mode_next     = first_mode;
                  pass_next     = 1'b0;
                  cs_sel_next   = CS_REG;
                  reg_data_next = {range_diap, key_for_mode(first_mode)};
               end else begin
                  state_next = S_DONE;
               end
            end
         end
         S_SET_REG: state_next = S_WAIT_REG;
         S_WAIT_REG: begin
            if (reg_done) begin
               state_next      = S_GEN_ON;
               cs_sel_next     = CS_DAC;
               gen_enable_next = 1'b1;
            end
         end
         S_GEN_ON: begin
            state_next   = S_SET_MUX;
            mux_chn_next = MUX_CURRENT;
         end
         S_SET_MUX: state_next = S_SETTLE;
         S_SETTLE: begin
            if (settle_zero) begin
               state_next = S_MEASURE;
            end
         end
         S_MEASURE: state_next = S_WAIT_ADC;
         S_WAIT_ADC: begin
            if (adc_done) begin
               state_next     = S_PUSH1;
               fifo_data_next = adc_data_1;
               data2_next     = adc_data_2;
            end
         end
         S_PUSH1: begin
            if (!fifo_full) begin
               state_next     = S_PUSH2;
               fifo_data_next = data2_reg;
            end
         end
         S_PUSH2: begin
            if (!fifo_full) begin
               if ((mode_reg == KEYS_W'(1)) || pass_reg) begin
                  state_next      = S_GEN_OFF;
                  gen_enable_next = 1'b0;
                  cs_sel_next     = CS_NONE;
                  mux_chn_next    = MUX_NONE;
               end else begin
                  state_next   = S_SET_MUX;
                  pass_next    = 1'b1;
                  mux_chn_next = MUX_POTENTIAL;
               end
            end
         end
         S_GEN_OFF: begin
            state_next = S_NEXT_MODE;
            pend_next  = pend_reg & ~cur_onehot;
         end
         S_NEXT_MODE: begin
            if (any_pend) begin
               state_next    = S_SET_REG;
               mode_next     = first_mode;
               pass_next     = 1'b0;
               cs_sel_next   = CS_REG;
               reg_data_next = {diap_reg, key_for_mode(first_mode)};
            end else begin
               state_next = S_DONE;
            end
         end
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      // Abort overrides everything decided above.
      if (abort && (state_reg != S_IDLE)) begin
         state_next      = S_IDLE;
         gen_enable_next = 1'b0;
         cs_sel_next     = CS_NONE;
         mux_chn_next    = MUX_NONE;
      end
   end

   assign gen_enable = gen_enable_reg;
   assign cs_sel     = cs_sel_reg;
   assign mux_chn    = mux_chn_reg;
   assign diap       = diap_reg;
   assign reg_data   = reg_data_reg;
   assign fifo_data  = fifo_data_reg;

   assign busy      = (state_reg != S_IDLE);
   assign done      = (state_reg == S_DONE);
   assign reg_start = (state_reg == S_SET_REG);
   assign adc_start = (state_reg == S_RANGE_SET) || (state_reg == S_MEASURE);
   assign adc_range = (state_reg == S_RANGE_SET) || (state_reg == S_RANGE_WAIT);
   assign fifo_wr   = ((state_reg == S_PUSH1) || (state_reg == S_PUSH2)) && !fifo_full;

endmodule

// File: tb/tb_meas_sequencer.sv
// ---------------------------------------------------------------------------
// tb_meas_sequencer
// Scoreboard bench: expected register words are queued when a sequence is
// launched, expected FIFO words when the ADC model returns a conversion;
// both are popped and compared when the DUT emits them.
// ---------------------------------------------------------------------------
module tb_meas_sequencer;
   import meas_sequencer_pkg::*;

   localparam int          NUM_MODES = 5;
   localparam int          DATA_W    = 24;
   localparam int          SETTLE_W  = 4;
   localparam logic [23:0] TH_LO     = 24'h200000;
   localparam logic [23:0] TH_HI     = 24'h600000;

   logic                 clk;
   logic                 rst;
   logic                 enable;
   logic                 abort;
   logic [NUM_MODES-1:0] mode_mask;
   logic [SETTLE_W-1:0]  settle_periods;
   logic                 gen_new_period;
   logic                 gen_enable;
   logic [7:0]           reg_data;
   logic                 reg_start;
   logic                 reg_done;
   logic [1:0]           cs_sel;
   logic [2:0]           mux_chn;
   logic                 adc_start;
   logic                 adc_range;
   logic                 adc_done;
   logic [DATA_W-1:0]    adc_data_1;
   logic [DATA_W-1:0]    adc_data_2;
   logic [DATA_W-1:0]    fifo_data;
   logic                 fifo_wr;
   logic                 fifo_full;
   logic                 busy;
   logic                 done;
   logic [2:0]           diap;

   meas_sequencer #(
      .NUM_MODES (NUM_MODES),
      .DATA_W    (DATA_W),
      .SETTLE_W  (SETTLE_W),
      .TH_LO     (TH_LO),
      .TH_HI     (TH_HI)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .abort          (abort),
      .mode_mask      (mode_mask),
      .settle_periods (settle_periods),
      .gen_new_period (gen_new_period),
      .gen_enable     (gen_enable),
      .reg_data       (reg_data),
      .reg_start      (reg_start),
      .reg_done       (reg_done),
      .cs_sel         (cs_sel),
      .mux_chn        (mux_chn),
      .adc_start      (adc_start),
      .adc_range      (adc_range),
      .adc_done       (adc_done),
      .adc_data_1     (adc_data_1),
      .adc_data_2     (adc_data_2),
      .fifo_data      (fifo_data),
      .fifo_wr        (fifo_wr),
      .fifo_full      (fifo_full),
      .busy           (busy),
      .done           (done),
      .diap           (diap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  reg_q[$];
   logic [23:0] word_q[$];

   logic [23:0] range_val = '0;
   bit          hold_full = 1'b0;
   int          cur_settle = 0;
   int          done_count = 0;
   int          words_seen = 0;
   int          range_done_cyc = 0;
   int          done_cyc = 0;
   int          pulses = 0;
   bit          counting = 1'b0;
   logic [2:0]  mux_prev = 3'b000;
   int          gcnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Generator: one pulse every 4 cycles.
   initial begin
      gen_new_period = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         gcnt++;
         gen_new_period = (gcnt % 4 == 0);
      end
   end

   // SPI register responder.
   initial begin
      reg_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reg_start && !rst) begin
            repeat (2) @(posedge clk);
            #1 reg_done = 1'b1;
            @(posedge clk);
            #1 reg_done = 1'b0;
         end
      end
   end

   // ADC responder: ranging returns range_val; measurements return random
   // data which is queued as the expected FIFO contents.
   initial begin : adc_model
      bit          rng;
      logic [23:0] d1, d2;
      adc_done   = 1'b0;
      adc_data_1 = '0;
      adc_data_2 = '0;
      fifo_full  = 1'b0;
      forever begin
         @(negedge clk);
         if (adc_start && !rst) begin
            rng = adc_range;
            repeat (2) @(posedge clk);
            #1;
            d1 = rng ? range_val : 24'($urandom);
            d2 = 24'($urandom);
            adc_data_1 = d1;
            adc_data_2 = d2;
            adc_done   = 1'b1;
            if (!rng) begin
               word_q.push_back(d1);
               word_q.push_back(d2);
               if (hold_full) fifo_full = 1'b1;
            end
            @(posedge clk);
            #1 adc_done = 1'b0;
            if (fifo_full) begin
               repeat (9) @(posedge clk);
               #1;
               fifo_full = 1'b0;
               hold_full = 1'b0;
            end
         end
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (reg_start) begin
            if (reg_q.size() == 0) begin
               check("reg_unexpected", reg_q.size(), 1);
            end else begin
               check("reg_data", reg_data, reg_q.pop_front());
               check("reg_cs", cs_sel, CS_REG);
            end
            $display("reg write %02h at cycle %0d", reg_data, cyc);
         end
         if (fifo_wr) begin
            check("wr_while_full", fifo_full, 0);
            words_seen++;
            if (word_q.size() == 0) begin
               check("fifo_unexpected", word_q.size(), 1);
            end else begin
               check("fifo_data", fifo_data, word_q.pop_front());
            end
            $display("fifo word %06h at cycle %0d", fifo_data, cyc);
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            check("done_busy", busy, 1);
         end
         if (adc_done && adc_range) range_done_cyc = cyc;
         if (adc_start && adc_range) begin
            check("range_mux", mux_chn, MUX_CURRENT);
         end
         if (adc_start && !adc_range) begin
            check("adc_gen_on", gen_enable, 1);
            check("adc_cs_dac", cs_sel, CS_DAC);
         end
         // Settle accounting: pulses seen after the mux-change cycle up to
         // the conversion start.
         if ((mux_chn != mux_prev) && (mux_chn != MUX_NONE)) begin
            pulses   = 0;
            counting = !adc_start;
         end else if (counting) begin
            if (adc_start) begin
               check("settle_pulses", pulses, cur_settle);
               counting = 1'b0;
            end else if (gen_new_period) begin
               pulses++;
            end
         end
         mux_prev = mux_chn;
      end
   end

   task automatic start_seq(input string name, input logic [4:0] mask, input int settle);
      bit ok;
      mode_mask      = mask;
      settle_periods = SETTLE_W'(settle);
      cur_settle     = settle;
      enable         = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("%s_start", name), ok, 1);
      @(posedge clk);
      #1 enable = 1'b0;
   endtask

   task automatic run_seq(input string name, input logic [4:0] mask, input int settle,
                          input logic [23:0] r, input bit full);
      logic [2:0] exp_diap;
      int         exp_words;
      int         d0;
      bit         ok;
      exp_diap  = (r < TH_LO) ? 3'b001 : ((r < TH_HI) ? 3'b010 : 3'b100);
      exp_words = 0;
      for (int m = 1; m <= NUM_MODES; m++) begin
         if (mask[m-1]) begin
            reg_q.push_back({exp_diap, 5'(m)});
            exp_words += (m == 1) ? 2 : 4;
         end
      end
      range_val  = r;
      hold_full  = full;
      words_seen = 0;
      d0         = done_count;
      start_seq(name, mask, settle);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_count != d0) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("%s_done", name), ok, 1);
      check($sformatf("%s_diap", name), diap, exp_diap);
      repeat (3) @(negedge clk);
      check($sformatf("%s_words", name), words_seen, exp_words);
      check($sformatf("%s_reg_left", name), reg_q.size(), 0);
      check($sformatf("%s_word_left", name), word_q.size(), 0);
      check($sformatf("%s_one_done", name), done_count - d0, 1);
      check($sformatf("%s_idle", name), busy, 0);
      $display("sequence %s mask %05b settle %0d r %06h finished", name, mask, settle, r);
      reg_q.delete();
      word_q.delete();
   endtask

   initial begin : main
      int d0;
      bit ok;
      rst            = 1'b1;
      enable         = 1'b0;
      abort          = 1'b0;
      mode_mask      = '0;
      settle_periods = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gen", gen_enable, 0);
      check("rst_cs", cs_sel, CS_NONE);
      check("rst_mux", mux_chn, MUX_NONE);
      check("rst_diap", diap, DIAP_20V);
      check("rst_reg_data", reg_data, 0);
      check("rst_fifo_data", fifo_data, 0);
      check("rst_busy", busy, 0);
      check("rst_strobes", {reg_start, adc_start, fifo_wr, done}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      run_seq("single", 5'b00001, 2, 24'h100000, 1'b0);
      run_seq("m2m5", 5'b10010, 1, 24'h700000, 1'b0);
      run_seq("full", 5'b00001, 0, 24'h5fffff, 1'b1);
      run_seq("nomask", 5'b00000, 0, TH_LO, 1'b0);
      check("range_to_done", done_cyc - range_done_cyc, 1);
      run_seq("th_hi", 5'b00000, 0, TH_HI, 1'b0);

      // Abort during SETTLE.
      range_val = 24'h300000;
      hold_full = 1'b0;
      d0        = done_count;
      reg_q.push_back(8'h41);
      start_seq("abort", 5'b00001, 8);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (gen_enable && (mux_chn == MUX_CURRENT)) begin
            ok = 1'b1;
            break;
         end
      end
      check("abort_reach_settle", ok, 1);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_gen", gen_enable, 0);
      check("abort_cs", cs_sel, CS_NONE);
      check("abort_mux", mux_chn, MUX_NONE);
      check("abort_idle", busy, 0);
      repeat (30) @(negedge clk);
      check("abort_no_done", done_count, d0);
      check("abort_reg_left", reg_q.size(), 0);
      $display("sequence abort finished");
      reg_q.delete();
      word_q.delete();

      run_seq("after_abort", 5'b00100, 3, 24'h000000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
